// File: rtl/wishbone_classic_to_up_pkg.sv
// ----------------------------------------------------------------------------
// wishbone_classic_to_up_pkg
//   Shared definitions for the Wishbone-classic to uP (req/ack) bridge:
//   FSM state type, parameter defaults and a helper that sizes the ack
//   timeout counter.
// ----------------------------------------------------------------------------
package wishbone_classic_to_up_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RESP
    } state_t;

    localparam int unsigned DEF_ADDRESS_WIDTH  = 32;
    localparam int unsigned DEF_BUS_WIDTH      = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wishbone_classic_to_up.sv
// ----------------------------------------------------------------------------
// wishbone_classic_to_up
//   Wishbone classic slave to uP (req/ack) bridge. Every Wishbone access maps
//   to exactly one uP read and/or write; partial byte-select writes are done
//   as read-modify-write. A uP slave that never acks yields a wb_err pulse.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   s_wb_cyc/stb/we           Wishbone cycle, strobe, write enable
//   s_wb_addr, s_wb_data_i    byte address, write data
//   s_wb_sel                  byte selects
//   s_wb_ack, s_wb_err        one-cycle completion / timeout pulses
//   s_wb_data_o               read data, valid while s_wb_ack=1
//   up_rreq/up_rack           uP read request pulse / ack
//   up_raddr, up_rdata        uP read address (word aligned) / read data
//   up_wreq/up_wack           uP write request pulse / ack
//   up_waddr, up_wdata        uP write address (word aligned) / write data
// ----------------------------------------------------------------------------
module wishbone_classic_to_up
    import wishbone_classic_to_up_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int unsigned BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_wb_cyc,
    input  logic                       s_wb_stb,
    input  logic                       s_wb_we,
    input  logic [ADDRESS_WIDTH-1:0]   s_wb_addr,
    input  logic [BUS_WIDTH*8-1:0]     s_wb_data_i,
    input  logic [BUS_WIDTH-1:0]       s_wb_sel,
    output logic                       s_wb_ack,
    output logic                       s_wb_err,
    output logic [BUS_WIDTH*8-1:0]     s_wb_data_o,
    output logic                       up_rreq,
    input  logic                       up_rack,
    output logic [ADDRESS_WIDTH-1:0]   up_raddr,
    input  logic [BUS_WIDTH*8-1:0]     up_rdata,
    output logic                       up_wreq,
    input  logic                       up_wack,
    output logic [ADDRESS_WIDTH-1:0]   up_waddr,
    output logic [BUS_WIDTH*8-1:0]     up_wdata
);

    localparam int unsigned DW = BUS_WIDTH * 8;
    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [ADDRESS_WIDTH-1:0] LOW_MASK = ADDRESS_WIDTH'(BUS_WIDTH - 1);

    state_t                     state_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [DW-1:0]              wb_data_q;
    logic [BUS_WIDTH-1:0]       sel_q;
    logic                       we_q;
    logic                       abort_q;
    logic [CW-1:0]              cnt_q;
    logic [DW-1:0]              wdata_q;
    logic [DW-1:0]              data_o_q;
    logic                       rreq_q;
    logic                       wreq_q;
    logic                       ack_q;
    logic                       err_q;

    logic                       timeout_hit;
    logic                       abort_now;
    logic                       sel_full;
    logic                       sel_none;
    logic [DW-1:0]              merge_d;

    // Byte i comes from the Wishbone write data when selected, else from the
    // value just read back from the uP slave.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0]        wr,
        input logic [DW-1:0]        rd,
        input logic [BUS_WIDTH-1:0] sel
    );
        logic [DW-1:0] m;
        m = rd;
        for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
            if (sel[i]) m[i*8 +: 8] = wr[i*8 +: 8];
        end
        return m;
    endfunction

    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIMIT);
        // A cycle dropped now or earlier in this access both count as abort.
        abort_now   = abort_q | ~s_wb_cyc;
        sel_full    = &s_wb_sel;
        sel_none    = ~|s_wb_sel;
        merge_d     = merge_bytes(wb_data_q, up_rdata, sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wb_data_q <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            data_o_q  <= '0;
            rreq_q    <= 1'b0;
            wreq_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rreq_q   <= 1'b0;
            wreq_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            data_o_q <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (s_wb_cyc && s_wb_stb) begin
                        addr_q    <= s_wb_addr & ~LOW_MASK;
                        wb_data_q <= s_wb_data_i;
                        sel_q     <= s_wb_sel;
                        we_q      <= s_wb_we;
                        abort_q   <= 1'b0;
                        cnt_q     <= '0;
                        if (s_wb_we && sel_none) begin
                            state_q <= ST_RESP;
                            ack_q   <= 1'b1;
                        end else if (s_wb_we && sel_full) begin
                            state_q <= ST_WR_REQ;
                            wreq_q  <= 1'b1;
                            wdata_q <= s_wb_data_i;
                        end else begin
                            state_q <= ST_RD_REQ;
                            rreq_q  <= 1'b1;
                        end
                    end
                end

                ST_RD_REQ, ST_RD_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!s_wb_cyc) abort_q <= 1'b1;
                    if (up_rack) begin
                        cnt_q <= '0;
                        if (abort_now) begin
                            // Aborted partial writes never issue the write.
                            state_q <= ST_IDLE;
                        end else if (!we_q) begin
                            state_q  <= ST_RESP;
                            ack_q    <= 1'b1;
                            data_o_q <= up_rdata;
                        end else begin
                            state_q <= ST_WR_REQ;
                            wreq_q  <= 1'b1;
                            wdata_q <= merge_d;
                        end
                    end else if (timeout_hit) begin
                        state_q <= abort_now ? ST_IDLE : ST_RESP;
                        err_q   <= ~abort_now;
                    end else begin
                        state_q <= ST_RD_WAIT;
                    end
                end

                ST_WR_REQ, ST_WR_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!s_wb_cyc) abort_q <= 1'b1;
                    if (up_wack) begin
                        cnt_q   <= '0;
                        state_q <= abort_now ? ST_IDLE : ST_RESP;
                        ack_q   <= ~abort_now;
                    end else if (timeout_hit) begin
                        state_q <= abort_now ? ST_IDLE : ST_RESP;
                        err_q   <= ~abort_now;
                    end else begin
                        state_q <= ST_WR_WAIT;
                    end
                end

                ST_RESP: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_wb_ack    = ack_q;
    assign s_wb_err    = err_q;
    assign s_wb_data_o = data_o_q;
    assign up_rreq     = rreq_q;
    assign up_wreq     = wreq_q;
    assign up_raddr    = addr_q;
    assign up_waddr    = addr_q;
    assign up_wdata    = wdata_q;

endmodule

// File: tb/tb_wishbone_classic_to_up.sv
// ----------------------------------------------------------------------------
// tb_wishbone_classic_to_up
//   Drives the bridge from a Wishbone master task against a behavioural uP
//   slave stub with programmable ack latency, a no-ack mode and stray acks.
// ----------------------------------------------------------------------------
module tb_wishbone_classic_to_up;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned DW = BW * 8;
    localparam int unsigned TO = 16;

    localparam logic [AW-1:0] GPIO_DATA  = 32'h000;
    localparam logic [AW-1:0] GPIO_TRI   = 32'h004;
    localparam logic [AW-1:0] GPIO2_DATA = 32'h008;
    localparam logic [AW-1:0] GPIO2_TRI  = 32'h00C;

    logic          clk;
    logic          rst;
    logic          s_wb_cyc, s_wb_stb, s_wb_we;
    logic [AW-1:0] s_wb_addr;
    logic [DW-1:0] s_wb_data_i;
    logic [BW-1:0] s_wb_sel;
    logic          s_wb_ack, s_wb_err;
    logic [DW-1:0] s_wb_data_o;
    logic          up_rreq, up_rack, up_wreq, up_wack;
    logic [AW-1:0] up_raddr, up_waddr;
    logic [DW-1:0] up_rdata, up_wdata;

    wishbone_classic_to_up #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_wb_cyc   (s_wb_cyc),
        .s_wb_stb   (s_wb_stb),
        .s_wb_we    (s_wb_we),
        .s_wb_addr  (s_wb_addr),
        .s_wb_data_i(s_wb_data_i),
        .s_wb_sel   (s_wb_sel),
        .s_wb_ack   (s_wb_ack),
        .s_wb_err   (s_wb_err),
        .s_wb_data_o(s_wb_data_o),
        .up_rreq    (up_rreq),
        .up_rack    (up_rack),
        .up_raddr   (up_raddr),
        .up_rdata   (up_rdata),
        .up_wreq    (up_wreq),
        .up_wack    (up_wack),
        .up_waddr   (up_waddr),
        .up_wdata   (up_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] sel;
        int unsigned   lat;
        logic          err;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] exp_wdata;
        int unsigned   exp_rd;
        int unsigned   exp_wr;
        int unsigned   exp_cyc;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    resp_t sb_q[$];

    // ---------------- uP slave stub ----------------
    logic [DW-1:0] mem [16];
    int unsigned   stub_lat;
    bit            stub_noack;
    bit            stub_stray;
    int unsigned   rreq_cnt, wreq_cnt, ack_cnt;
    bit            pending, pend_wr;
    int unsigned   pend_cnt;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_wdata;
    logic [AW-1:0] exp_req_addr;
    logic [DW-1:0] exp_req_wdata;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            up_rack = 1'b0;
            up_wack = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (up_rreq || up_wreq) begin
                    check("single_outstanding", {up_rreq & up_wreq, pending}, 0);
                    if (up_rreq) begin
                        rreq_cnt++;
                        check("raddr", up_raddr, exp_req_addr);
                    end
                    if (up_wreq) begin
                        wreq_cnt++;
                        check("waddr", up_waddr, exp_req_addr);
                        check("wdata", up_wdata, exp_req_wdata);
                    end
                    if (!stub_noack) begin
                        pending    = 1'b1;
                        pend_wr    = up_wreq;
                        pend_addr  = up_wreq ? up_waddr : up_raddr;
                        pend_wdata = up_wdata;
                        pend_cnt   = stub_lat;
                    end
                end
                if (pending) begin
                    if (pend_cnt == 0) begin
                        if (pend_wr) begin
                            check("wdata_hold", up_wdata, exp_req_wdata);
                            mem[pend_addr[5:2]] = pend_wdata;
                            up_wack = 1'b1;
                        end else begin
                            up_rdata = mem[pend_addr[5:2]];
                            up_rack  = 1'b1;
                        end
                        pending = 1'b0;
                    end else begin
                        pend_cnt--;
                    end
                end else if (stub_stray) begin
                    up_rdata   = 32'hFFFF0000;
                    up_rack    = 1'b1;
                    up_wack    = 1'b1;
                    stub_stray = 1'b0;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (s_wb_ack || s_wb_err) begin
                if (s_wb_ack) ack_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b required none", s_wb_ack, s_wb_err);
                end else begin
                    r = sb_q.pop_front();
                    check("resp_kind", {s_wb_ack, s_wb_err}, r.err ? 2'b01 : 2'b10);
                    check("resp_data", s_wb_data_o, r.data);
                end
            end
        end
    end

    // ---------------- Wishbone master ----------------
    // Called at posedge+2; returns at posedge+2 of the cycle after the response.
    task automatic run_vec(input vec_t v);
        int unsigned rd0, wr0, n;
        bit done;
        rd0 = rreq_cnt;
        wr0 = wreq_cnt;
        stub_lat      = v.lat;
        exp_req_addr  = v.addr & ~32'h3;
        exp_req_wdata = v.exp_wdata;
        sb_q.push_back('{data: v.exp_data, err: v.err});
        s_wb_cyc    = 1'b1;
        s_wb_stb    = 1'b1;
        s_wb_we     = v.we;
        s_wb_addr   = v.addr;
        s_wb_data_i = v.data;
        s_wb_sel    = v.sel;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (s_wb_ack || s_wb_err) done = 1'b1;
            else n++;
        end
        if (!done) begin
            void'(sb_q.pop_back());
            checks++;
            failures++;
            $display("FAIL resp_wait: got no response in 200 cycles required one");
        end else begin
            check("latency", n, v.exp_cyc);
        end
        @(posedge clk);
        #2;
        s_wb_cyc = 1'b0;
        s_wb_stb = 1'b0;
        check("rreq_count", rreq_cnt - rd0, v.exp_rd);
        check("wreq_count", wreq_cnt - wr0, v.exp_wr);
    endtask

    function automatic vec_t rd_vec(input logic [AW-1:0] a, input int unsigned lat, input logic [DW-1:0] d);
        return '{1'b0, a, 32'h0, 4'hF, lat, 1'b0, d, 32'h0, 1, 0, 2 + lat};
    endfunction

    initial begin
        #300us;
        $display("FAIL watchdog: got no finish required finish before 300us");
        $fatal(1, "watchdog");
    end

    vec_t vecs [12];

    initial begin
        int unsigned rd0, wr0, ack0;
        vec_t to_vec;

        vecs[0]  = '{1'b1, GPIO_TRI,   32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'h0,        32'hFFFFFFFF, 0, 1, 2};
        vecs[1]  = rd_vec(GPIO_TRI, 1, 32'hFFFFFFFF);
        vecs[2]  = '{1'b1, GPIO_DATA,  32'hBABEDEAD, 4'hF, 2, 1'b0, 32'h0,        32'hBABEDEAD, 0, 1, 4};
        vecs[3]  = '{1'b1, GPIO_DATA,  32'h0000BEEF, 4'h3, 1, 1'b0, 32'h0,        32'hBABEBEEF, 1, 1, 5};
        vecs[4]  = rd_vec(GPIO_DATA, 0, 32'hBABEBEEF);
        vecs[5]  = '{1'b1, GPIO2_DATA, 32'h12345678, 4'hF, 3, 1'b0, 32'h0,        32'h12345678, 0, 1, 5};
        vecs[6]  = '{1'b1, GPIO2_DATA, 32'hAABBCCDD, 4'hA, 0, 1'b0, 32'h0,        32'hAA34CC78, 1, 1, 3};
        vecs[7]  = rd_vec(32'h00B, 2, 32'hAA34CC78);
        vecs[8]  = '{1'b1, GPIO2_TRI,  32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0,        32'h0,        0, 0, 1};
        vecs[9]  = rd_vec(GPIO2_TRI, 1, 32'h0BADF00D);
        vecs[10] = '{1'b1, GPIO_TRI,   32'h00000000, 4'h1, 0, 1'b0, 32'h0,        32'hFFFFFF00, 1, 1, 3};
        vecs[11] = rd_vec(32'h006, 0, 32'hFFFFFF00);

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[3] = 32'h0BADF00D;
        stub_lat = 0; stub_noack = 1'b0; stub_stray = 1'b0;
        rreq_cnt = 0; wreq_cnt = 0; ack_cnt = 0; pending = 1'b0;
        exp_req_addr = '0; exp_req_wdata = '0;
        up_rack = 1'b0; up_wack = 1'b0; up_rdata = '0;
        rst = 1'b1;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        s_wb_addr = '0; s_wb_data_i = '0; s_wb_sel = '0;

        @(negedge clk);
        check("reset_outputs", {s_wb_ack, s_wb_err, s_wb_data_o, up_rreq, up_raddr,
                                up_wreq, up_waddr, up_wdata}, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Slave never acks: error pulse 17 cycles after the request.
        stub_noack = 1'b1;
        to_vec = '{1'b0, GPIO_DATA, 32'h0, 4'hF, 0, 1'b1, 32'h0, 32'h0, 1, 0, 18};
        run_vec(to_vec);
        stub_noack = 1'b0;

        // Late / stray acks while idle must not produce a response.
        ack0 = ack_cnt;
        rd0  = rreq_cnt;
        stub_stray = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("stray_ack_ignored", ack_cnt - ack0, 0);
        check("stray_no_req", rreq_cnt - rd0, 0);
        run_vec(rd_vec(GPIO_TRI, 1, 32'hFFFFFF00));

        // Abort a read while waiting for the uP ack.
        rd0 = rreq_cnt; wr0 = wreq_cnt;
        stub_lat = 6; exp_req_addr = GPIO_DATA;
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b0;
        s_wb_addr = GPIO_DATA; s_wb_sel = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        check("abort_rd_rreq", rreq_cnt - rd0, 1);
        check("abort_rd_wreq", wreq_cnt - wr0, 0);

        // Abort a partial write during its read phase: the write is dropped.
        rd0 = rreq_cnt; wr0 = wreq_cnt;
        stub_lat = 4; exp_req_addr = GPIO_DATA;
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
        s_wb_addr = GPIO_DATA; s_wb_data_i = 32'h11112222; s_wb_sel = 4'h3;
        repeat (3) @(posedge clk);
        #2;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        check("abort_wr_rreq", rreq_cnt - rd0, 1);
        check("abort_wr_wreq", wreq_cnt - wr0, 0);
        run_vec(rd_vec(GPIO_DATA, 0, 32'hBABEBEEF));

        // Reset while waiting for a write ack.
        stub_lat = 8; exp_req_addr = GPIO2_TRI; exp_req_wdata = 32'h5555AAAA;
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
        s_wb_addr = GPIO2_TRI; s_wb_data_i = 32'h5555AAAA; s_wb_sel = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_write", {s_wb_ack, s_wb_err, s_wb_data_o, up_rreq, up_raddr,
                                  up_wreq, up_waddr, up_wdata}, 0);
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        run_vec(rd_vec(GPIO2_TRI, 1, 32'h0BADF00D));

        // 100 back-to-back reads.
        ack0 = ack_cnt;
        rd0  = rreq_cnt;
        for (int i = 0; i < 100; i++) run_vec(rd_vec(GPIO2_DATA, i % 3, 32'hAA34CC78));
        check("b2b_acks", ack_cnt - ack0, 100);
        check("b2b_rreqs", rreq_cnt - rd0, 100);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
